// File: rtl/serial_word_packer.sv
// serial_word_packer: gathers `size` serial bits (MSB first) under a start /
// serValid handshake, computes a parity flag, and presents the word together
// with a one-cycle ld strobe to a downstream data/flag register.
//
// Handshake: start is sampled only in IDLE and opens a frame. serIn is taken
// only on a posedge where serValid=1 while in SHIFT. After the size-th valid
// bit, the FSM spends exactly one cycle in LOAD (ld=1), then returns to IDLE.
// start and serValid are ignored outside IDLE and SHIFT respectively.
module serial_word_packer #(
  parameter int size       = 2,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            serIn,
  input  logic            serValid,
  output logic            ld,
  output logic [size-1:0] packedData,
  output logic            packedFlag,
  output logic            busy
);

  localparam int CNT_W = $clog2(size + 1);

  // State is kept in a named enum so checkers can bind to it by name.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t          state;
  state_t          nextState;
  logic [size-1:0] shReg;
  logic [size-1:0] shNext;
  logic [CNT_W-1:0] bitCnt;
  logic            acc;
  logic            accNext;
  logic            lastBit;

  // Shift value after taking serIn; a one-bit word simply becomes serIn.
  generate
    if (size == 1) begin : gSingle
      assign shNext = serIn;
    end else begin : gMulti
      assign shNext = {shReg[size-2:0], serIn};
    end
  endgenerate

  assign accNext = acc ^ serIn;
  // True on the edge that captures the final bit of the frame.
  assign lastBit = serValid && (bitCnt == CNT_W'(size - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start)   nextState = SHIFT;
      SHIFT:   if (lastBit) nextState = LOAD;
      LOAD:                 nextState = IDLE;
      default:              nextState = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    ld   = 1'b0;
    busy = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      LOAD: begin
        ld   = 1'b1;
        busy = 1'b1;
      end
      default: begin
        ld   = 1'b0;
        busy = 1'b0;
      end
    endcase
  end

  // Frame datapath: cleared when a frame opens, advanced on each valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shReg  <= '0;
      bitCnt <= '0;
      acc    <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        shReg  <= '0;
        bitCnt <= '0;
        acc    <= 1'b0;
      end
    end else if (state == SHIFT && serValid) begin
      shReg <= shNext;
      acc   <= accNext;
      // Counter saturates at size; it never wraps within a frame.
      if (bitCnt != CNT_W'(size)) bitCnt <= bitCnt + CNT_W'(1);
    end
  end

  // Output word/flag registers, loaded on entry to LOAD and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      packedData <= '0;
      packedFlag <= 1'b0;
    end else if (state == SHIFT && lastBit) begin
      packedData <= shNext;
      packedFlag <= accNext ^ ODD_PARITY;
    end
  end

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed bench for serial_word_packer: a size=2 even-parity instance with a
// small downstream register model, and a size=4 odd-parity instance.
module tb_serial_word_packer;

  logic       clk;
  logic       rst;
  logic       start, serIn, serValid;
  logic       ld, packedFlag, busy;
  logic [1:0] packedData;
  logic       start4, serIn4, serValid4;
  logic       ld4, packedFlag4, busy4;
  logic [3:0] packedData4;

  // Downstream register model (inputData / inputData_ / ld).
  logic [1:0] regData;
  logic       regFlag;

  int total;
  int bad;

  // Expected {packedData, packedFlag} for each ld pulse of the size=2 instance.
  logic [2:0] exp_q[$];

  serial_word_packer #(.size(2), .ODD_PARITY(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .serIn(serIn), .serValid(serValid),
    .ld(ld), .packedData(packedData), .packedFlag(packedFlag), .busy(busy)
  );

  serial_word_packer #(.size(4), .ODD_PARITY(1'b1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .serIn(serIn4), .serValid(serValid4),
    .ld(ld4), .packedData(packedData4), .packedFlag(packedFlag4), .busy(busy4)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      regData <= 2'b00;
      regFlag <= 1'b0;
    end else if (ld) begin
      regData <= packedData;
      regFlag <= packedFlag;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ld pulse must match the next queued expectation.
  always @(posedge clk) begin
    #1;
    if (ld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("ld_unexpected", 32'd1, 32'd0);
      end else begin
        check_eq("sb_word", {29'd0, packedData, packedFlag}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks: inputs change 1 time unit after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serValid = 1'b1;
    serIn    = b;
    step();
    serValid = 1'b0;
    serIn    = 1'b0;
  endtask

  task automatic send_bit4(input logic b);
    serValid4 = 1'b1;
    serIn4    = b;
    step();
    serValid4 = 1'b0;
    serIn4    = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; serIn = 1'b0; serValid = 1'b0;
    start4 = 1'b0; serIn4 = 1'b0; serValid4 = 1'b0;

    // Test 1: reset, then frame 1,0
    step(); step();
    check_eq("rst_ld", ld, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", packedData, 0);
    check_eq("rst_flag", packedFlag, 0);
    check_eq("rst_busy4", busy4, 0);
    rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check_eq("t1_busy_shift", busy, 1);
    check_eq("t1_ld_shift", ld, 0);
    send_bit(1'b1);
    check_eq("t1_ld_mid", ld, 0);
    exp_q.push_back({2'b10, 1'b1});
    send_bit(1'b0);
    check_eq("t1_ld", ld, 1);
    check_eq("t1_data", packedData, 2'b10);
    check_eq("t1_flag", packedFlag, 1);
    step();
    check_eq("t1_ld_after", ld, 0);
    check_eq("t1_busy_after", busy, 0);
    check_eq("t1_data_hold", packedData, 2'b10);
    // Test 6: register holds the word through idle cycles
    check_eq("t6_reg_data", regData, 2'b10);
    check_eq("t6_reg_flag", regFlag, 1);
    step(); step();
    check_eq("t6_reg_data_hold", regData, 2'b10);
    check_eq("t6_reg_flag_hold", regFlag, 1);

    // Test 2: gaps between valid bits
    start = 1'b1; step(); start = 1'b0;
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t2_gap_ld", ld, 0);
      check_eq("t2_gap_busy", busy, 1);
    end
    exp_q.push_back({2'b11, 1'b0});
    send_bit(1'b1);
    check_eq("t2_ld", ld, 1);
    check_eq("t2_data", packedData, 2'b11);
    check_eq("t2_flag", packedFlag, 0);
    step();
    check_eq("t2_ld_after", ld, 0);

    // Test 3: start held high, back-to-back frames
    start = 1'b1;
    step();
    send_bit(1'b0);
    exp_q.push_back({2'b01, 1'b1});
    send_bit(1'b1);
    check_eq("t3a_ld", ld, 1);
    check_eq("t3a_data", packedData, 2'b01);
    check_eq("t3a_flag", packedFlag, 1);
    step();
    check_eq("t3_idle_ld", ld, 0);
    check_eq("t3_idle_busy", busy, 0);
    step();
    check_eq("t3_reshift_busy", busy, 1);
    start = 1'b0;
    send_bit(1'b1);
    exp_q.push_back({2'b11, 1'b0});
    send_bit(1'b1);
    check_eq("t3b_ld", ld, 1);
    check_eq("t3b_data", packedData, 2'b11);
    check_eq("t3b_flag", packedFlag, 0);
    step();

    // Test 4: reset in mid-frame discards it
    start = 1'b1; step(); start = 1'b0;
    send_bit(1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("t4_ld", ld, 0);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_data", packedData, 0);
    check_eq("t4_flag", packedFlag, 0);
    start = 1'b1; step(); start = 1'b0;
    send_bit(1'b1);
    exp_q.push_back({2'b11, 1'b0});
    send_bit(1'b1);
    check_eq("t4_data_fresh", packedData, 2'b11);
    check_eq("t4_ld_fresh", ld, 1);
    step();

    // Test 5: size=4, odd parity, serValid pulses in IDLE and LOAD ignored
    send_bit4(1'b1);
    check_eq("t5_idle_busy", busy4, 0);
    check_eq("t5_idle_data", packedData4, 0);
    start4 = 1'b1; step(); start4 = 1'b0;
    send_bit4(1'b1);
    send_bit4(1'b0);
    send_bit4(1'b1);
    check_eq("t5_ld_early", ld4, 0);
    send_bit4(1'b1);
    check_eq("t5_ld", ld4, 1);
    check_eq("t5_data", packedData4, 4'b1011);
    check_eq("t5_flag", packedFlag4, 0);
    send_bit4(1'b0);
    check_eq("t5_after_ld", ld4, 0);
    check_eq("t5_after_busy", busy4, 0);
    check_eq("t5_after_data", packedData4, 4'b1011);
    send_bit4(1'b1);
    check_eq("t5_idle2_busy", busy4, 0);
    check_eq("t5_idle2_data", packedData4, 4'b1011);
    check_eq("t5_idle2_flag", packedFlag4, 0);

    step();
    check_eq("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
